// File: rtl/bcd_pkg.sv
// Shared decimal-arithmetic definitions: radix constants, the BCD digit type
// and the serial subtractor's state encoding.
package bcd_pkg;

  localparam int unsigned BCD_RADIX = 10;
  localparam int unsigned BCD_MAX   = 9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  function automatic logic digit_valid(input bcd_digit_t d);
    return d <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor: d = a - b - br with decimal borrow,
// plus a flag when either input digit is not a legal BCD value.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t i_a,
  input  bcd_digit_t i_b,
  input  logic       i_br,
  output bcd_digit_t o_d,
  output logic       o_br,
  output logic       o_dig_err
);

  logic [4:0] w_sub;

  always_comb begin
    w_sub = {1'b0, i_b} + {4'b0000, i_br};
    if ({1'b0, i_a} >= w_sub) begin
      o_d  = 4'({1'b0, i_a} - w_sub);
      o_br = 1'b0;
    end else begin
      // Borrow one ten from the next digit up.
      o_d  = 4'({1'b0, i_a} + 5'(BCD_RADIX) - w_sub);
      o_br = 1'b1;
    end
    o_dig_err = !digit_valid(i_a) || !digit_valid(i_b);
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial multi-digit BCD subtractor: one decimal digit per clock, LSD first,
// ten's-complement difference with borrow-out, invalid-digit flag and done pulse.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_e r_state, w_state_nxt;

  logic [W-1:0]     r_a, r_b, r_res, r_diff;
  logic             r_br, r_err_acc, r_bout, r_err;
  logic [IDX_W-1:0] r_idx;

  bcd_digit_t       w_d;
  logic             w_br_nxt, w_dig_err, w_last, w_err_all;
  logic [W-1:0]     w_res_shift;

  bcd_digit_sub u_digit_sub (
    .i_a      (r_a[3:0]),
    .i_b      (r_b[3:0]),
    .i_br     (r_br),
    .o_d      (w_d),
    .o_br     (w_br_nxt),
    .o_dig_err(w_dig_err)
  );

  assign w_last      = (r_idx == IDX_W'(DIGITS - 1));
  assign w_err_all   = r_err_acc | w_dig_err;
  // New digit enters at the top so digit 0 ends up in [3:0] after DIGITS steps.
  assign w_res_shift = (r_res >> 4) | (W'(w_d) << (W - 4));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_br      <= 1'b0;
      r_err_acc <= 1'b0;
      r_idx     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_br      <= bin;
            r_res     <= '0;
            r_err_acc <= 1'b0;
            r_idx     <= '0;
          end
        end
        RUN: begin
          r_a       <= r_a >> 4;
          r_b       <= r_b >> 4;
          r_br      <= w_br_nxt;
          r_res     <= w_res_shift;
          r_err_acc <= w_err_all;
          r_idx     <= r_idx + IDX_W'(1);
          if (w_last) begin
            // An invalid digit anywhere suppresses the numeric result.
            r_diff <= w_err_all ? '0 : w_res_shift;
            r_bout <= w_err_all ? 1'b0 : w_br_nxt;
            r_err  <= w_err_all;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial: directed cases, start-held-high, mid-run
// reset and randomized operands against an integer-arithmetic reference model.
module tb_bcd_sub_serial;

  localparam int DIG = 4;
  localparam int W   = 4 * DIG;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, bout, err;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_sub_serial #(.DIGITS(DIG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .err  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit has_bad(input logic [W-1:0] x);
    for (int i = 0; i < DIG; i++) if (x[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bcd_val(input logic [W-1:0] x);
    int v = 0;
    for (int i = DIG - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: plain integer subtraction with ten's-complement wrap.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                       output logic [W-1:0] d, output logic bo, output logic e);
    int pow = 1;
    int r;
    for (int i = 0; i < DIG; i++) pow = pow * 10;
    e = has_bad(av) || has_bad(bv);
    r = bcd_val(av) - bcd_val(bv) - int'(bv_in);
    bo = (r < 0);
    if (r < 0) r = r + pow;
    d = to_bcd(r);
    if (e) begin
      d  = '0;
      bo = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit bad);
    logic [W-1:0] r;
    for (int i = 0; i < DIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (bad) r[4*$urandom_range(0, DIG - 1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // Call and return at #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    logic [W-1:0] ed;
    logic eb, ee;
    int cyc;
    model(av, bv, bv_in, ed, eb, ee);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("busy_on", W'(busy), W'(1));
    check("done_early", W'(done), W'(0));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", W'(cyc), W'(DIG));
    check("diff", diff, ed);
    check("bout", W'(bout), W'(eb));
    check("err", W'(err), W'(ee));
    @(posedge clk); #1;
    check("done_pulse", W'(done), W'(0));
    check("busy_off", W'(busy), W'(0));
    check("diff_hold", diff, ed);
  endtask

  initial begin
    logic [W-1:0] ed;
    logic eb, ee;
    int cyc;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_diff", diff, W'(0));
    check("rst_bout", W'(bout), W'(0));
    check("rst_err", W'(err), W'(0));
    rst_n = 1'b1;

    run_op(16'h5432, 16'h1234, 1'b0);
    check("plan_4198", diff, 16'h4198);
    run_op(16'h1000, 16'h0001, 1'b0);
    check("plan_0999", diff, 16'h0999);
    run_op(16'h0000, 16'h0001, 1'b0);
    check("plan_9999a", {diff[W-1:1], bout}, {15'h4CCC, 1'b1});
    run_op(16'h9999, 16'h9999, 1'b1);
    check("plan_9999b", diff, 16'h9999);
    run_op(16'h12A4, 16'h0000, 1'b0);
    check("plan_err", W'(err), W'(1));
    run_op(16'h0000, 16'h0000, 1'b0);

    // start held high; operands change while the first operation runs
    a = 16'h8765; b = 16'h4321; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0500; b = 16'h0499; bin = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold1_lat", W'(cyc), W'(DIG));
    check("hold1_diff", diff, 16'h4444);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!busy && cyc < 20);
    check("hold_restart", W'(cyc), W'(2));
    a = 16'h1111; b = 16'h2222; bin = 1'b0;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold2_lat", W'(cyc), W'(DIG));
    check("hold2_diff", diff, 16'h0000);
    check("hold2_bout", W'(bout), W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_more", W'(busy), W'(0));

    // reset during RUN after a nonzero result is on the outputs
    run_op(16'h0000, 16'h0001, 1'b0);
    a = 16'h7777; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", W'(busy), W'(0));
    check("mrst_done", W'(done), W'(0));
    check("mrst_diff", diff, W'(0));
    check("mrst_bout", W'(bout), W'(0));
    check("mrst_err", W'(err), W'(0));
    cyc = 0;
    repeat (DIG + 2) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    check("mrst_no_done", W'(cyc), W'(0));
    rst_n = 1'b1;
    run_op(16'h7777, 16'h1111, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(rand_bcd(($urandom_range(0, 9) == 0)), rand_bcd(($urandom_range(0, 9) == 0)),
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
